// File: rtl/fejkon_button_if.sv
// fejkon_button_if: Avalon-MM slave port plus level interrupt for the button block
interface fejkon_button_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;
  modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata, irq);
  modport slave (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata, irq);
endinterface

// File: rtl/fejkon_button.sv
// fejkon_button: debounced board buttons/switches with sticky press/release events on Avalon-MM; FEJKON_BUTTON_LONGPRESS_EN adds long-press events
module fejkon_button #(
  parameter int Inputs = 4,
  parameter int ReferenceClock = 50000000,
  parameter int DebounceMs = 20,
  parameter int LongPressMs = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [Inputs-1:0] button_n,
  output logic [Inputs-1:0] pressed,
  fejkon_button_if.slave    avs
);
  localparam int DebounceCycles = ReferenceClock / 1000 * DebounceMs;
  localparam int CW = $clog2(DebounceCycles) + 1;
  localparam logic [CW-1:0] CntLast = CW'(DebounceCycles - 1);
  localparam logic [31:0] LoMask = 32'((64'd1 << Inputs) - 64'd1);
`ifdef FEJKON_BUTTON_LONGPRESS_EN
  localparam logic [31:0] EvMask = LoMask | (LoMask << 16);
`else
  localparam logic [31:0] EvMask = LoMask;
`endif
  logic [Inputs-1:0] meta_q, sync_q, sync, pressed_q, pressed_d, rise, fall, lp_set;
  logic [CW-1:0] cnt_q [Inputs];
  logic [CW-1:0] cnt_d [Inputs];
  logic [31:0] press_q, press_d, release_q, release_d, mask_q, mask_d, rdata_q, rdata_d;
  logic irq_q, irq_d, wr_press, wr_release, wr_mask;

  // two-flop synchroniser; flops idle at the released (high) level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= button_n;
      sync_q <= meta_q;
    end

  assign sync = ~sync_q;

  // pressed follows sync only after DebounceCycles consecutive disagreeing clocks
  always_comb begin
    pressed_d = pressed_q;
    for (int i = 0; i < Inputs; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != pressed_q[i]) begin
        if (cnt_q[i] == CntLast) pressed_d[i] = sync[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise = pressed_d & ~pressed_q;
  assign fall = ~pressed_d & pressed_q;

`ifdef FEJKON_BUTTON_LONGPRESS_EN
  localparam int LongPressCycles = ReferenceClock / 1000 * LongPressMs;
  localparam int LW = $clog2(LongPressCycles + 1);
  logic [LW-1:0] lp_q [Inputs];
  logic [LW-1:0] lp_d [Inputs];

  // hold timer per input; parks one past the threshold so the event fires once per hold
  always_comb
    for (int i = 0; i < Inputs; i++) begin
      lp_d[i] = !pressed_q[i] ? '0 : lp_q[i] == LW'(LongPressCycles) ? lp_q[i] : lp_q[i] + LW'(1);
      lp_set[i] = pressed_q[i] && lp_q[i] == LW'(LongPressCycles - 1);
    end

  // hold timer registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lp_q <= '{default: '0};
    else lp_q <= lp_d;
`else
  assign lp_set = '0;
`endif

  assign wr_press   = avs.avs_write && avs.avs_address == 2'd1;
  assign wr_release = avs.avs_write && avs.avs_address == 2'd2;
  assign wr_mask    = avs.avs_write && avs.avs_address == 2'd3;

  // sticky events where a new event beats a same-cycle clear; reads return pre-write values
  always_comb begin
    press_d   = ((press_q & ~(wr_press ? avs.avs_writedata : '0)) | 32'(rise) | (32'(lp_set) << 16)) & EvMask;
    release_d = ((release_q & ~(wr_release ? avs.avs_writedata : '0)) | 32'(fall)) & LoMask;
    mask_d    = wr_mask ? avs.avs_writedata & EvMask : mask_q;
    irq_d     = |((press_q | release_q) & mask_q);
    rdata_d   = !avs.avs_read ? rdata_q :
                avs.avs_address == 2'd0 ? 32'(pressed_q) :
                avs.avs_address == 2'd1 ? press_q :
                avs.avs_address == 2'd2 ? release_q : mask_q;
  end

  // debounce state, event, mask, interrupt and read-data registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pressed_q <= '0;
      cnt_q     <= '{default: '0};
      press_q   <= '0;
      release_q <= '0;
      mask_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end

  assign pressed          = pressed_q;
  assign avs.avs_readdata = rdata_q;
  assign avs.irq          = irq_q;
endmodule

// File: doc/fejkon_button.md
Name: fejkon_button

Overview:
- Input-side counterpart of the board LED driver: samples the board's active-low push buttons and DIP switches.
- Synchronises and debounces every input, presents debounced levels, and latches press/release events in sticky registers.
- Exposes status through an Avalon-MM slave with a level interrupt, for the management CPU to read board controls.
- Sits in the slow board-management clock domain alongside the LED block.

Parameters:
- Inputs, 4: number of button/switch inputs, 1..16.
- ReferenceClock, 50000000: clk frequency in Hz.
- DebounceMs, 20: required stable time in ms. DebounceCycles = ReferenceClock/1000*DebounceMs, must be >= 2.
- LongPressMs, 1000: long-press threshold in ms. LongPressCycles = ReferenceClock/1000*LongPressMs. Used only with the optional feature.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- button_n  in  Inputs  raw board inputs, active-low, asynchronous to clk
- pressed  out  Inputs  debounced level, 1 = pressed
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, read latency 1
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- irq  out  1  level interrupt

Behaviour:
- Reset: asynchronous active-low, one clock (clk).
  - Synchroniser flops reset to 1 (released).
  - pressed, counters, PRESS, RELEASE, IRQ_MASK, avs_readdata and irq reset to 0.
- Sync: two-flop synchroniser per bit, then inverted to active-high sync[i].
- Debounce, per input:
  - Counter cnt[i], width $clog2(DebounceCycles)+1.
  - If sync[i]==pressed[i]: cnt <= 0.
  - Else if cnt == DebounceCycles-1: pressed[i] <= sync[i] and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DebounceCycles clocks never changes pressed.
  - Latency from a clean edge on button_n to pressed is DebounceCycles+2 clocks.
- Events:
  - pressed 0->1 sets PRESS[i]; pressed 1->0 sets RELEASE[i].
  - Event bits are sticky.
  - If a set and a W1C clear of the same bit fall in the same cycle, the set wins.
- Register map (word addresses):
  - 0 STATE: RO, [Inputs-1:0] = pressed. Writes are ignored.
  - 1 PRESS: W1C. [Inputs-1:0] press events; [16+Inputs-1:16] long-press events (optional feature).
  - 2 RELEASE: W1C, [Inputs-1:0].
  - 3 IRQ_MASK: RW. [Inputs-1:0] enables press/release events of input i. [16+Inputs-1:16] enables long-press events.
  - Unused bits read 0 and ignore writes.
- Read:
  - avs_readdata is registered and valid the clock after avs_read.
  - It holds its value until the next read.
  - No waitrequest.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- irq:
  - Registered: irq <= |((PRESS|RELEASE) & mask) over both bit groups.
  - Asserts 1 clock after the causing event bit is set.
  - Deasserts 1 clock after the last enabled bit clears.

Optional Feature:
- Macro: FEJKON_BUTTON_LONGPRESS_EN.
- When defined:
  - Per-input counter lp[i] runs while pressed[i]=1.
  - When lp reaches LongPressCycles-1, PRESS[16+i] sets once and lp saturates.
  - lp clears when pressed[i]=0.
  - Mask bits [16+i] are implemented.
- When undefined:
  - No lp counters are built.
  - PRESS[31:16] and IRQ_MASK[31:16] read 0 and ignore writes.

Test Plan:
Parameters for all scenarios: ReferenceClock=1000000, DebounceMs=1 (1000 cycles), LongPressMs=5, Inputs=4.
1. Assert reset_n=0 mid-count with button_n=4'b1110 -> pressed=0, irq=0, avs_readdata=0. After release with input held, pressed[0]=1 exactly 1002 clocks later.
2. button_n[0] falls cleanly and is held 3000 clocks -> pressed[0] rises at clock 1002. Read addr 1 returns 0x00000001; addr 0 returns 0x1.
3. button_n[1] toggles every 300 clocks for 3000 clocks, then is held low -> exactly one PRESS[1] set, 1002 clocks after the final edge. No RELEASE[1].
4. IRQ_MASK=0x1, press input 0 -> irq=1 one clock after PRESS[0]. Write 0x1 to addr 1 -> irq=0 next clock. Repeat with the W1C landing on the set cycle -> PRESS[0] stays 1 and irq stays 1.
5. Release input 2 after a press -> RELEASE=0x4. Write 0xFFFFFFFF to addr 0 -> STATE unchanged. Read addr 3 after writing 0xFFFFFFFF -> 0x000F000F with the macro, 0x0000000F without.
6. With FEJKON_BUTTON_LONGPRESS_EN, hold input 3 for 8000 clocks -> PRESS[19] sets 5000 clocks after pressed[3] rises, only once. Without the macro, PRESS[19] reads 0.
